packet_wrr_arbiter: RTL

Parametrised weighted round-robin packet arbiter granting one of N requesters exclusive ownership of a shared downstream port for the whole duration of a packet. Grant is taken on request and released only on the owner's `fin` pulse. Successor to the fixed 4-channel packet RR arbiter, adding per-channel weights (consecutive-packet quotas), an encoded grant index and an optional ownership watchdog. Sits between the packet sources and the shared output mux / downstream sink.

---
 rtl/pkt_arb_pkg.sv | 28 ++
 rtl/packet_wrr_arbiter_rr_pick.sv | 34 +++
 rtl/packet_wrr_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_arb_pkg;

   // Arbiter FSM: waiting for a winner, or a packet owner holds the port.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Widest weight field the quota helper handles.
   localparam int MAX_WEIGHT_W = 16;

   // Index width for N requesters; never narrower than one bit.
   function automatic int id_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end
      return 1;
   endfunction

   // Effective quota: a programmed weight of zero behaves as one.
   function automatic logic [MAX_WEIGHT_W-1:0] eff_weight(input logic [MAX_WEIGHT_W-1:0] w);
      return (w == '0) ? MAX_WEIGHT_W'(1) : w;
   endfunction

endpackage

// File: rtl/packet_wrr_arbiter_rr_pick.sv
// Rotating priority encoder: first requester after ptr, wrapping to ptr last.
// Latency: purely combinational.
// Backpressure: none; holds no state.
module rr_pick
   import pkt_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan ptr+1 .. ptr+N (mod N) and take the first active request.
   always_comb begin
      int c;
      c      = 0;
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int i = 1; i <= N; i++) begin
         c = (int'(ptr) + i) % N;
         if (!valid && req[c]) begin
            valid     = 1'b1;
            onehot[c] = 1'b1;
            idx       = IW'(c);
         end
      end
   end

endmodule

// File: rtl/packet_wrr_arbiter.sv
// Weighted round-robin packet arbiter; owner keeps the port until its fin pulse.
// Latency: grant registered one edge after req+ready; released one edge after fin.
// Backpressure: ready low stalls new grants only; optional watchdog via PKT_ARB_TIMEOUT_EN.
module packet_wrr_arbiter
   import pkt_arb_pkg::*;
#(
   parameter int N              = 4,
   parameter int WEIGHT_W       = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N-1:0]          req,
   input  logic [N-1:0]          fin,
   input  logic                  ready,
   input  logic [N*WEIGHT_W-1:0] weight,
   output logic [N-1:0]          grant,
   output logic [id_w(N)-1:0]    grant_id,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int IW = id_w(N);

   state_t              state, state_nxt;
   logic [IW-1:0]       ptr, ptr_nxt;
   logic [WEIGHT_W-1:0] cred, cred_nxt;
   logic [N-1:0]        grant_nxt;
   logic [IW-1:0]       grant_id_nxt;
   logic                timeout_err_nxt;
   logic                timeout_hit;

   logic [N-1:0]        pick_onehot;
   logic [IW-1:0]       pick_idx;
   logic                pick_valid;

   logic [WEIGHT_W-1:0] w_arr [N];
   logic [WEIGHT_W-1:0] quota_ptr;
   logic [N-1:0]        ptr_onehot;

   // Split the flat weight bus into per-channel fields.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
      end
   end

   assign quota_ptr  = WEIGHT_W'(eff_weight(MAX_WEIGHT_W'(w_arr[ptr])));
   assign ptr_onehot = {{(N-1){1'b0}}, 1'b1} << ptr;
   assign busy       = (state == GRANT);

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

`ifdef PKT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt;

   // Count cycles spent in GRANT; zero whenever a grant starts or ends.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
      end else if (state == GRANT && state_nxt == GRANT) begin
         wd_cnt <= wd_cnt + CW'(1);
      end else begin
         wd_cnt <= '0;
      end
   end

   assign timeout_hit = (state == GRANT) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, arbitration and release decisions.
   always_comb begin
      state_nxt       = state;
      ptr_nxt         = ptr;
      cred_nxt        = cred;
      grant_nxt       = grant;
      grant_id_nxt    = grant_id;
      timeout_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (ready && pick_valid) begin
               state_nxt = GRANT;
               // cred == 0 means no quota in progress, so reset gives channel 0 priority.
               if (req[ptr] && (cred != '0) && (cred < quota_ptr)) begin
                  grant_nxt    = ptr_onehot;
                  grant_id_nxt = ptr;
                  cred_nxt     = cred + WEIGHT_W'(1);
               end else begin
                  grant_nxt    = pick_onehot;
                  grant_id_nxt = pick_idx;
                  ptr_nxt      = pick_idx;
                  cred_nxt     = WEIGHT_W'(1);
               end
            end
         end
         GRANT: begin
            if (fin[grant_id]) begin
               state_nxt = IDLE;
               grant_nxt = '0;
            end else if (timeout_hit) begin
               state_nxt       = IDLE;
               grant_nxt       = '0;
               timeout_err_nxt = 1'b1;
               // Saturate so the revoked owner's quota reads as used up.
               cred_nxt        = '1;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ptr         <= IW'(N - 1);
         cred        <= '0;
         grant       <= '0;
         grant_id    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         cred        <= cred_nxt;
         grant       <= grant_nxt;
         grant_id    <= grant_id_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

endmodule
